// File: rtl/irq_ctrl_pkg.sv
// Shared register map, sentinel values and the channel mask helper for irq_ctrl.
package irq_ctrl_pkg;

  localparam int          MAX_IRQ = 16;
  localparam logic [15:0] NO_IRQ  = 16'hFFFF;

  typedef enum logic [1:0] {
    REG_PENDING = 2'd0,
    REG_ENABLE  = 2'd1,
    REG_MODE    = 2'd2,
    REG_CLAIM   = 2'd3
  } reg_off_e;

  // Ones in the low n bit positions: the channels that physically exist.
  function automatic logic [MAX_IRQ-1:0] chan_mask(input int n);
    logic [MAX_IRQ-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_IRQ; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// Register bus between a core-side master and irq_ctrl; the slave answers with a one-cycle mem_ready.
interface irq_ctrl_if;
  logic        sel;
  logic        mem_valid;
  logic [15:0] mem_addr;
  logic [1:0]  mem_wstrb;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output sel, mem_valid, mem_addr, mem_wstrb, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  sel, mem_valid, mem_addr, mem_wstrb, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder over the active channel vector; purely combinational.
module irq_prio_enc #(
  parameter int NUM_IRQ = 8
) (
  input  logic [NUM_IRQ-1:0] vec,
  output logic [3:0]         idx,
  output logic               found
);

  // Scan from the top so the last hit, the lowest index, is what remains.
  always_comb begin
    found = 1'b0;
    idx   = 4'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (vec[i]) begin
        found = 1'b1;
        idx   = 4'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: PENDING/ENABLE/MODE/CLAIM registers, mem_ready RESP_WAIT+1 cycles after a request,
// one request at a time. Define IRQ_CTRL_SYNC_EN to put a 2-flop synchroniser on every irq_src bit.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_IRQ   = 8,
  parameter int RESP_WAIT = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_src,
  irq_ctrl_if.slave          bus,
  output logic               irq
);

  localparam logic [15:0] IMASK = chan_mask(NUM_IRQ);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} st_e;

  st_e         st;
  logic [1:0]  wait_cnt;
  logic        ready_q;
  reg_off_e    req_off;
  logic [1:0]  req_wstrb;
  logic [15:0] req_wdata;

  logic [15:0] pend_q, en_q, mode_q, prev_q;
  logic [15:0] pend_n, en_n, mode_n;
  logic [15:0] samp, rise, to_edge, wmask, w1c, cclr, rd;
  logic [NUM_IRQ-1:0] samp_raw, act;
  logic [3:0]  claim_idx;
  logic        claim_found;
  logic        is_wr;
  logic        unused_addr_bits;

`ifdef IRQ_CTRL_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_src;
      sync2_q <= sync1_q;
    end
  end

  assign samp_raw = sync2_q;
`else
  assign samp_raw = irq_src;
`endif

  always_comb begin
    samp                = '0;
    samp[NUM_IRQ-1:0]   = samp_raw;
  end

  assign act = pend_q[NUM_IRQ-1:0] & en_q[NUM_IRQ-1:0];

  irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio_enc (
    .vec   (act),
    .idx   (claim_idx),
    .found (claim_found)
  );

  assign unused_addr_bits = ^{bus.mem_addr[15:3], bus.mem_addr[0]};

  // All register side effects are keyed off ready_q, i.e. they land on the edge closing the mem_ready cycle.
  always_comb begin
    is_wr   = |req_wstrb;
    wmask   = {{8{req_wstrb[1]}}, {8{req_wstrb[0]}}};
    en_n    = en_q;
    mode_n  = mode_q;
    w1c     = '0;
    cclr    = '0;
    if (ready_q && is_wr && req_off == REG_ENABLE)  en_n   = ((en_q   & ~wmask) | (req_wdata & wmask)) & IMASK;
    if (ready_q && is_wr && req_off == REG_MODE)    mode_n = ((mode_q & ~wmask) | (req_wdata & wmask)) & IMASK;
    if (ready_q && is_wr && req_off == REG_PENDING) w1c    = req_wdata & wmask;
    if (ready_q && !is_wr && req_off == REG_CLAIM && claim_found) cclr = 16'd1 << claim_idx;
    rise    = samp & ~prev_q;
    to_edge = mode_n & ~mode_q;
    // Level bits follow the source (or drop when turning edge); edge bits set on rise, which beats any clear.
    pend_n  = IMASK & ((~mode_q & ~to_edge & samp) |
                       (mode_q & (rise | (pend_q & ~(w1c | cclr)))));
  end

  always_comb begin
    rd = '0;
    case (req_off)
      REG_PENDING: rd = pend_q;
      REG_ENABLE:  rd = en_q;
      REG_MODE:    rd = mode_q;
      REG_CLAIM:   rd = claim_found ? {12'd0, claim_idx} : NO_IRQ;
      default:     rd = '0;
    endcase
  end

  assign bus.mem_rdata = ready_q ? rd : 16'h0000;
  assign bus.mem_ready = ready_q;
  assign irq           = |(pend_q & en_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      en_q   <= '0;
      mode_q <= '0;
      prev_q <= '0;
    end else begin
      pend_q <= pend_n;
      en_q   <= en_n;
      mode_q <= mode_n;
      prev_q <= samp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= ST_IDLE;
      wait_cnt  <= 2'd0;
      ready_q   <= 1'b0;
      req_off   <= REG_PENDING;
      req_wstrb <= 2'b00;
      req_wdata <= 16'h0000;
    end else begin
      case (st)
        ST_IDLE: begin
          if (bus.sel && bus.mem_valid && !ready_q) begin
            req_off   <= reg_off_e'(bus.mem_addr[2:1]);
            req_wstrb <= bus.mem_wstrb;
            req_wdata <= bus.mem_wdata;
            if (RESP_WAIT == 0) begin
              ready_q <= 1'b1;
              st      <= ST_RESP;
            end else begin
              wait_cnt <= 2'(RESP_WAIT);
              st       <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 2'd1) begin
            ready_q <= 1'b1;
            st      <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        ST_RESP: begin
          ready_q <= 1'b0;
          st      <= ST_IDLE;
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 8, number of interrupt channels, legal range 1..16.
REQ-002 SHALL have parameter RESP_WAIT, default 0, extra wait cycles before mem_ready, legal range 0..3.
REQ-003 SHALL have port clk  input  1  single clock; all state on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port irq_src  input  NUM_IRQ  raw interrupt sources.
REQ-006 SHALL have port sel  input  1  external address decoder selects this block.
REQ-007 SHALL have port mem_valid  input  1  bus request.
REQ-008 SHALL have port mem_addr  input  16  byte address; only bits [2:1] decoded.
REQ-009 SHALL have port mem_wstrb  input  2  byte write strobes; 2'b00 means read.
REQ-010 SHALL have port mem_wdata  input  16  write data.
REQ-011 SHALL have port mem_rdata  output  16  read data.
REQ-012 SHALL have port mem_ready  output  1  one-cycle completion pulse.
REQ-013 SHALL have port irq  output  1  interrupt request to the core.

Function
REQ-014 Register map by mem_addr[2:1]: 0 PENDING, 1 ENABLE, 2 MODE (1=edge, 0=level), 3 CLAIM.
REQ-015 Handshake: when sel & mem_valid & !mem_ready, wait RESP_WAIT cycles, then assert mem_ready for exactly one cycle; no back-to-back acceptance in the mem_ready cycle.
REQ-016 Side effects (writes, W1C, claim-clear) occur only in the mem_ready cycle; mem_rdata valid only when mem_ready=1, else 16'h0000.
REQ-017 Writes honour strobes: wstrb[0] updates bits 7:0, wstrb[1] bits 15:8.
REQ-018 Bits at index >= NUM_IRQ read 0 and ignore writes in every register.
REQ-019 Edge channel: rising edge of sampled source (sampled value 1, previous sample 0) sets PENDING bit.
REQ-020 Level channel: PENDING bit equals current sampled source each cycle; writes to it ignored.
REQ-021 PENDING write: 1 bits clear edge-channel pending; 0 bits no effect.
REQ-022 Simultaneous set and clear (edge detected in W1C or claim cycle): set wins.
REQ-023 CLAIM read returns lowest index with PENDING&ENABLE=1, zero-extended, or 16'hFFFF if none; if that channel is edge mode its PENDING bit clears.
REQ-024 CLAIM write: ignored, still acknowledged.
REQ-025 irq = |(PENDING & ENABLE), combinational from registers; no glitches from bus inputs.
REQ-026 Latency without sync: source high at posedge t (previously low) -> PENDING and irq high after posedge t+1.
REQ-027 MODE change from edge to level: PENDING bit takes the level value next cycle; level to edge: bit clears, previous-sample register retained.

Reset
REQ-028 On rst: PENDING, ENABLE, MODE, previous-sample and synchroniser flops = 0; wait counter = 0; mem_ready=0, mem_rdata=0, irq=0.
REQ-029 Reset mid-transaction aborts it; no mem_ready for the aborted request, no side effects applied.

Configuration
REQ-030 Macro IRQ_CTRL_SYNC_EN defined: each irq_src passes a 2-flop synchroniser before edge/level logic, adding 2 cycles to REQ-026 latency.
REQ-031 IRQ_CTRL_SYNC_EN undefined: irq_src sampled directly by the previous-sample flop; latency as REQ-026.

Structure
REQ-032 Package irq_ctrl_pkg SHALL hold register offset enum, NO_IRQ = 16'hFFFF, MAX_IRQ = 16.
REQ-033 Sub-module irq_prio_enc SHALL compute lowest-index valid channel and a found flag, parametrised by NUM_IRQ.

Verification
REQ-034 NUM_IRQ=8, RESP_WAIT=0: write ENABLE=16'h00FF, MODE=16'h00FF, pulse irq_src[3] one cycle -> PENDING reads 16'h0008, irq=1.
REQ-035 Pending channels 5 and 2, all enabled edge -> CLAIM reads 2 then 5 then 16'hFFFF; irq drops after second claim.
REQ-036 Level channel 1 held high, W1C PENDING=16'h0002 -> PENDING still 16'h0002; release source -> 16'h0000 next cycle.
REQ-037 RESP_WAIT=2: read ENABLE -> mem_ready exactly 3 cycles after request, one cycle wide, rdata 0 otherwise.
REQ-038 Edge on channel 0 in same cycle as W1C of bit 0 -> PENDING bit 0 remains 1; wstrb=2'b10 write of ENABLE=16'hFFFF with NUM_IRQ=12 -> ENABLE reads 16'h0F00.
REQ-039 Assert rst during outstanding RESP_WAIT=3 write -> no mem_ready, ENABLE=0, irq=0.
